switch_cleanup_counter: RTL and testbench

Upstream stage of the 4-digit 7-segment display interface. It synchronises and debounces one raw mechanical switch, then emits a single-cycle press pulse per clean rising edge. It counts presses in 4-digit BCD and drives the display interface's value[15:0] and dots[3:0] inputs directly. It runs on the same 5 MHz clock as the display interface.

---
 rtl/display_pkg.sv | 21 ++
 rtl/bcd_digit.sv | 28 ++
 rtl/switch_cleanup_counter.sv | 160 ++++++++++++++++
 tb/tb_switch_cleanup_counter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and timing defaults for the switch front-end of the 4-digit 7-segment display.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Timing defaults derived from the 5 MHz display clock
    localparam int CLK_HZ                = 5_000_000;
    localparam int DEFAULT_DEBOUNCE      = CLK_HZ / 100;   // 10 ms
    localparam int DEFAULT_REPEAT_DELAY  = CLK_HZ / 2;     // 0.5 s
    localparam int DEFAULT_REPEAT_PERIOD = CLK_HZ / 10;    // 0.1 s

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the press counter; carry is combinational so digits ripple in one clock.
module bcd_digit
    import display_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       inc,
    output logic [3:0] digit,
    output logic       carry
);

    bcd_t digit_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            digit_reg <= '0;
        end else if (clear) begin
            digit_reg <= '0;
        end else if (inc) begin
            digit_reg <= (digit_reg == BCD_MAX) ? 4'd0 : digit_reg + 4'd1;
        end
    end

    assign digit = digit_reg;
    assign carry = inc && (digit_reg == BCD_MAX);

endmodule

// File: rtl/switch_cleanup_counter.sv
// Synchronise, debounce and count presses of one mechanical switch as 4-digit BCD.
// Define SWITCH_AUTOREPEAT_EN to generate repeat pulses while the switch is held.
module switch_cleanup_counter
    import display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sw_raw,
    input  logic        clear,
    output logic        sw_clean,
    output logic        press_pulse,
    output logic [15:0] value,
    output logic [3:0]  dots
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_reg, s2_reg;
    sw_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             commit_press;
    logic             pulse_next;
    logic             sw_clean_reg;
    logic             press_pulse_reg;
    logic             wrap_reg;
    logic [4:0]       inc_chain;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s1_reg <= sw_raw;
            s2_reg <= s1_reg;
        end
    end

    // A level change commits only after s2 holds for DEBOUNCE_CYCLES consecutive wait clocks
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        commit_press = 1'b0;
        case (state_reg)
            IDLE_LOW: begin
                if (s2_reg) begin
                    state_next = WAIT_HIGH;
                    cnt_next   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s2_reg) begin
                    state_next = IDLE_LOW;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next   = IDLE_HIGH;
                    commit_press = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            IDLE_HIGH: begin
                if (!s2_reg) begin
                    state_next = WAIT_LOW;
                    cnt_next   = '0;
                end
            end
            WAIT_LOW: begin
                if (s2_reg) begin
                    state_next = IDLE_HIGH;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE_LOW;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE_LOW;
        endcase
    end

`ifdef SWITCH_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt_reg;
    logic             rpt_armed_reg;
    logic             rpt_fire;

    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; armed marks the switch-over
    assign rpt_fire = (state_reg == IDLE_HIGH) &&
                      (rpt_armed_reg ? (rpt_cnt_reg == RPT_W'(REPEAT_PERIOD - 1))
                                     : (rpt_cnt_reg == RPT_W'(REPEAT_DELAY - 1)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rpt_cnt_reg   <= '0;
            rpt_armed_reg <= 1'b0;
        end else if (state_reg != IDLE_HIGH) begin
            rpt_cnt_reg   <= '0;
            rpt_armed_reg <= 1'b0;
        end else if (rpt_fire) begin
            rpt_cnt_reg   <= '0;
            rpt_armed_reg <= 1'b1;
        end else begin
            rpt_cnt_reg <= rpt_cnt_reg + 1'b1;
        end
    end

    assign pulse_next = commit_press || rpt_fire;
`else
    assign pulse_next = commit_press;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE_LOW;
            cnt_reg         <= '0;
            sw_clean_reg    <= 1'b0;
            press_pulse_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            sw_clean_reg    <= (state_next == IDLE_HIGH) || (state_next == WAIT_LOW);
            press_pulse_reg <= pulse_next;
        end
    end

    assign inc_chain[0] = press_pulse_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            bcd_digit u_digit (
                .clock (clock),
                .reset (reset),
                .clear (clear),
                .inc   (inc_chain[gi]),
                .digit (value[gi*4 +: 4]),
                .carry (inc_chain[gi+1])
            );
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrap_reg <= 1'b0;
        end else if (clear) begin
            wrap_reg <= 1'b0;
        end else if (inc_chain[4]) begin
            wrap_reg <= 1'b1;
        end
    end

    assign sw_clean    = sw_clean_reg;
    assign press_pulse = press_pulse_reg;
    assign dots        = {wrap_reg, 2'b00, sw_clean_reg};

endmodule

// File: tb/tb_switch_cleanup_counter.sv
// Directed bench: per-cycle vector table for debounce timing, plus sequences for
// counting, clear priority, mid-debounce reset, 9999 wrap and (optionally) auto-repeat.
module tb_switch_cleanup_counter;

    logic        clock;
    logic        reset;
    logic        sw_raw, clear;
    logic        sw_clean, press_pulse;
    logic [15:0] value;
    logic [3:0]  dots;

    logic        w_sw_raw, w_clear;
    logic        w_sw_clean, w_press_pulse;
    logic [15:0] w_value;
    logic [3:0]  w_dots;

    int n_checks = 0;
    int n_fail   = 0;
    int w_pulses = 0;

    switch_cleanup_counter #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sw_raw      (sw_raw),
        .clear       (clear),
        .sw_clean    (sw_clean),
        .press_pulse (press_pulse),
        .value       (value),
        .dots        (dots)
    );

    // Short debounce instance so 10000 presses fit in a modest run
    switch_cleanup_counter #(
        .DEBOUNCE_CYCLES (2),
        .REPEAT_DELAY    (1000),
        .REPEAT_PERIOD   (1000)
    ) dut_w (
        .clock       (clock),
        .reset       (reset),
        .sw_raw      (w_sw_raw),
        .clear       (w_clear),
        .sw_clean    (w_sw_clean),
        .press_pulse (w_press_pulse),
        .value       (w_value),
        .dots        (w_dots)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (w_press_pulse) w_pulses <= w_pulses + 1;
    end

    typedef struct {
        logic        sw;
        logic        clr;
        logic        exp_clean;
        logic        exp_pulse;
        logic [15:0] exp_value;
        logic [3:0]  exp_dots;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic sw, input logic clr, input logic ec,
                                input logic ep, input logic [15:0] ev, input logic [3:0] ed);
        vec_t v;
        v.sw = sw; v.clr = clr; v.exp_clean = ec; v.exp_pulse = ep;
        v.exp_value = ev; v.exp_dots = ed;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out, got no event expected event", name);
    endtask

    // Raise the switch until the press is accepted, then release until sw_clean falls
    task automatic do_press();
        bit seen;
        sw_raw = 1'b1;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clock);
            if (press_pulse) seen = 1;
        end
        if (!seen) timeout("press_rise");
        sw_raw = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clock);
            if (!sw_clean) seen = 1;
        end
        if (!seen) timeout("press_fall");
        @(negedge clock);
    endtask

    task automatic w_cycle();
        w_sw_raw = 1'b1;
        repeat (3) @(negedge clock);
        w_sw_raw = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        bit seen;
        int pulses;
        reset = 1'b0; sw_raw = 1'b1; clear = 1'b0;
        w_sw_raw = 1'b0; w_clear = 1'b0;

        // Debounce timing from reset release, release, glitch rejection and clear
        for (int i = 0; i < 10; i++)
            add(1, 0, i >= 6, i == 6, (i >= 7) ? 16'h0001 : 16'h0000, {3'b000, i >= 6});
        for (int i = 0; i < 8; i++)
            add(0, 0, i < 6, 0, 16'h0001, {3'b000, i < 6});
        for (int i = 0; i < 16; i++)
            add((i < 8) && (i % 4 < 2), 0, 0, 0, 16'h0001, 4'b0000);
        add(0, 1, 0, 0, 16'h0000, 4'b0000);
        add(0, 0, 0, 0, 16'h0000, 4'b0000);

        repeat (3) @(negedge clock);
        check("reset_sw_clean", {15'd0, sw_clean}, 16'd0);
        check("reset_pulse", {15'd0, press_pulse}, 16'd0);
        check("reset_value", value, 16'h0000);
        check("reset_dots", {12'd0, dots}, 16'd0);
        check("reset_w_value", w_value, 16'h0000);

        reset = 1'b1;
        foreach (vecs[i]) begin
            sw_raw = vecs[i].sw;
            clear  = vecs[i].clr;
            @(negedge clock);
            check($sformatf("row%0d_sw_clean", i), {15'd0, sw_clean}, {15'd0, vecs[i].exp_clean});
            check($sformatf("row%0d_pulse", i), {15'd0, press_pulse}, {15'd0, vecs[i].exp_pulse});
            check($sformatf("row%0d_value", i), value, vecs[i].exp_value);
            check($sformatf("row%0d_dots", i), {12'd0, dots}, {12'd0, vecs[i].exp_dots});
        end
        clear = 1'b0;

        // 42 presses exercise the units->tens carry
        for (int p = 0; p < 42; p++) do_press();
        check("count_42", value, 16'h0042);

        // Clear coinciding with a press pulse wins and the press is lost
        sw_raw = 1'b1;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clock);
            if (press_pulse) seen = 1;
        end
        if (!seen) timeout("clear_press_rise");
        check("clear_press_before", value, 16'h0042);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("clear_press_value", value, 16'h0000);
        sw_raw = 1'b0;
        repeat (10) @(negedge clock);
        check("clear_press_after", value, 16'h0000);
        check("clear_press_dots", {12'd0, dots}, 16'd0);

        // Reset in WAIT_HIGH with cnt=2, then a full debounce from scratch
        do_press();
        check("pre_reset_value", value, 16'h0001);
        sw_raw = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        #1;
        check("midreset_value", value, 16'h0000);
        check("midreset_sw_clean", {15'd0, sw_clean}, 16'd0);
        check("midreset_pulse", {15'd0, press_pulse}, 16'd0);
        check("midreset_dots", {12'd0, dots}, 16'd0);
        @(negedge clock);
        reset = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (press_pulse) pulses++;
            check($sformatf("rerelease%0d_sw_clean", k), {15'd0, sw_clean}, {15'd0, k >= 7});
            check($sformatf("rerelease%0d_pulse", k), {15'd0, press_pulse}, {15'd0, k == 7});
        end
        sw_raw = 1'b0;
        repeat (10) @(negedge clock);
        check("rerelease_pulses", 16'(pulses), 16'd1);
        check("rerelease_value", value, 16'h0001);
        check("rerelease_dots", {12'd0, dots}, 16'd0);

        // 9999 presses, then one more to wrap and set the sticky flag
        for (int p = 0; p < 9999; p++) w_cycle();
        repeat (10) @(negedge clock);
        check("w_pulses_9999", 16'(w_pulses), 16'd9999);
        check("w_value_9999", w_value, 16'h9999);
        check("w_dots_9999", {12'd0, w_dots}, 16'd0);
        w_cycle();
        repeat (10) @(negedge clock);
        check("w_value_wrap", w_value, 16'h0000);
        check("w_dots_wrap", {12'd0, w_dots}, 16'h0008);
        w_clear = 1'b1;
        @(negedge clock);
        w_clear = 1'b0;
        check("w_dots_clear", {12'd0, w_dots}, 16'd0);
        check("w_value_clear", w_value, 16'h0000);

        // Long hold: repeats when the feature is built in, a single press otherwise
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        sw_raw = 1'b1;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clock);
            if (press_pulse) seen = 1;
        end
        if (!seen) timeout("hold_rise");
        for (int j = 1; j <= 30; j++) begin
            @(negedge clock);
`ifdef SWITCH_AUTOREPEAT_EN
            check($sformatf("hold%0d_pulse", j), {15'd0, press_pulse},
                  {15'd0, (j >= 10) && ((j - 10) % 5 == 0)});
`else
            check($sformatf("hold%0d_pulse", j), {15'd0, press_pulse}, 16'd0);
`endif
        end
        sw_raw = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (press_pulse) pulses++;
        end
        check("hold_release_pulses", 16'(pulses), 16'd0);
`ifdef SWITCH_AUTOREPEAT_EN
        check("hold_value", value, 16'h0006);
`else
        check("hold_value", value, 16'h0001);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
